// File: rtl/axi_tdd_ng_counter.sv
// TDD timing master: arm on enable, wait for sync, optional startup delay, then frame bursts.
// Optional AXI_TDD_NG_SYNC_RESTART_EN lets sync restart the sequence while RUNNING.
package axi_tdd_ng_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    WAITING = 2'd2,
    RUNNING = 2'd3
  } state_t;
endpackage

module axi_tdd_ng_counter
  import axi_tdd_ng_pkg::*;
#(
  parameter int REGISTER_WIDTH = 32,
  parameter int BURST_WIDTH    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      sync,
  input  logic [REGISTER_WIDTH-1:0] startup_delay,
  input  logic [REGISTER_WIDTH-1:0] frame_length,
  input  logic [BURST_WIDTH-1:0]    burst_count,
  output logic [REGISTER_WIDTH-1:0] tdd_counter,
  output state_t                    tdd_cstate,
  output logic                      tdd_enable,
  output logic                      tdd_endof_frame,
  output logic                      burst_done
);

  localparam logic [REGISTER_WIDTH-1:0] CNT_ONE   = REGISTER_WIDTH'(1);
  localparam logic [BURST_WIDTH-1:0]    FRAME_ONE = BURST_WIDTH'(1);

  state_t                    state_q, state_d;
  logic [REGISTER_WIDTH-1:0] counter_q, counter_d;
  logic                      eof_q, eof_d;
  logic                      ten_q, ten_d;
  logic                      done_q, done_d;
  logic [REGISTER_WIDTH-1:0] delay_q, delay_d;
  logic [REGISTER_WIDTH-1:0] flen_q, flen_d;
  logic [BURST_WIDTH-1:0]    burst_q, burst_d;
  logic [BURST_WIDTH-1:0]    frames_q, frames_d;
  // stop_q marks the extra end-of-frame cycle issued after a disable.
  logic                      stop_q, stop_d;
  logic [BURST_WIDTH-1:0]    frames_inc;
  logic                      frames_remain;
`ifdef AXI_TDD_NG_SYNC_RESTART_EN
  logic                      restart_q, restart_d;
`endif

  always_comb begin
    state_d       = state_q;
    counter_d     = counter_q;
    delay_d       = delay_q;
    flen_d        = flen_q;
    burst_d       = burst_q;
    frames_d      = frames_q;
    done_d        = 1'b0;
    stop_d        = 1'b0;
    frames_inc    = frames_q + FRAME_ONE;
    frames_remain = (burst_q == '0) || (frames_inc < burst_q);
`ifdef AXI_TDD_NG_SYNC_RESTART_EN
    restart_d     = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        counter_d = '0;
        if (enable) begin
          state_d = ARMED;
          delay_d = startup_delay;
          flen_d  = frame_length;
          burst_d = burst_count;
        end
      end

      ARMED: begin
        counter_d = '0;
        frames_d  = '0;
        if (!enable) begin
          state_d = IDLE;
        end else if (sync) begin
          state_d = (delay_q != '0) ? WAITING : RUNNING;
        end
      end

      WAITING: begin
        if (!enable) begin
          state_d   = IDLE;
          counter_d = '0;
        end else if (counter_q == delay_q - CNT_ONE) begin
          state_d   = RUNNING;
          counter_d = '0;
        end else begin
          counter_d = counter_q + CNT_ONE;
        end
      end

      RUNNING: begin
        if (stop_q) begin
          state_d   = IDLE;
          counter_d = '0;
`ifdef AXI_TDD_NG_SYNC_RESTART_EN
        end else if (restart_q) begin
          counter_d = '0;
          frames_d  = '0;
          if (!enable) begin
            state_d = IDLE;
          end else begin
            state_d = (delay_q != '0) ? WAITING : RUNNING;
          end
`endif
        end else if (!enable) begin
          // A strobe already on the bus doubles as the idle-polarity strobe.
          if (eof_q) begin
            state_d   = IDLE;
            counter_d = '0;
          end else begin
            stop_d = 1'b1;
          end
        end else if (eof_q && !frames_remain) begin
          state_d   = ARMED;
          counter_d = '0;
          frames_d  = '0;
          done_d    = 1'b1;
`ifdef AXI_TDD_NG_SYNC_RESTART_EN
        end else if (sync) begin
          restart_d = 1'b1;
`endif
        end else if (eof_q) begin
          counter_d = '0;
          frames_d  = frames_inc;
        end else begin
          counter_d = counter_q + CNT_ONE;
        end
      end

      default: begin
        state_d   = IDLE;
        counter_d = '0;
      end
    endcase

    eof_d = (state_d == RUNNING) && ((counter_d == flen_q) || stop_d
`ifdef AXI_TDD_NG_SYNC_RESTART_EN
            || restart_d
`endif
            );
    ten_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      counter_q <= '0;
      eof_q     <= 1'b0;
      ten_q     <= 1'b0;
      done_q    <= 1'b0;
      delay_q   <= '0;
      flen_q    <= '0;
      burst_q   <= '0;
      frames_q  <= '0;
      stop_q    <= 1'b0;
`ifdef AXI_TDD_NG_SYNC_RESTART_EN
      restart_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      eof_q     <= eof_d;
      ten_q     <= ten_d;
      done_q    <= done_d;
      delay_q   <= delay_d;
      flen_q    <= flen_d;
      burst_q   <= burst_d;
      frames_q  <= frames_d;
      stop_q    <= stop_d;
`ifdef AXI_TDD_NG_SYNC_RESTART_EN
      restart_q <= restart_d;
`endif
    end
  end

  assign tdd_counter     = counter_q;
  assign tdd_cstate      = state_q;
  assign tdd_enable      = ten_q;
  assign tdd_endof_frame = eof_q;
  assign burst_done      = done_q;

endmodule

// File: tb/tb_axi_tdd_ng_counter.sv
// Bench for axi_tdd_ng_counter: a vector table for the reference burst, then hand-written corner sequences.
module tb_axi_tdd_ng_counter;
  import axi_tdd_ng_pkg::*;

  localparam int RW = 32;
  localparam int BW = 32;
  localparam int W  = RW + 5;

  logic          clk = 1'b0;
  logic          rst, enable, sync;
  logic [RW-1:0] startup_delay, frame_length;
  logic [BW-1:0] burst_count;
  logic [RW-1:0] tdd_counter;
  state_t        tdd_cstate;
  logic          tdd_enable, tdd_endof_frame, burst_done;

  axi_tdd_ng_counter #(.REGISTER_WIDTH(RW), .BURST_WIDTH(BW)) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .sync           (sync),
    .startup_delay  (startup_delay),
    .frame_length   (frame_length),
    .burst_count    (burst_count),
    .tdd_counter    (tdd_counter),
    .tdd_cstate     (tdd_cstate),
    .tdd_enable     (tdd_enable),
    .tdd_endof_frame(tdd_endof_frame),
    .burst_done     (burst_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          en;
    logic          sy;
    state_t        st;
    logic [RW-1:0] cnt;
    logic          eof;
    logic          done;
  } vec_t;

  vec_t       tbl[$];
  logic [W-1:0] exp_q[$];
  logic       care_q[$];
  int         n_vec  = 0;
  int         n_fail = 0;

  function automatic void add(input logic r, input logic e, input logic s, input state_t st,
                              input int c, input logic eof, input logic done);
    vec_t v;
    v.rst = r; v.en = e; v.sy = s; v.st = st;
    v.cnt = c; v.eof = eof; v.done = done;
    tbl.push_back(v);
  endfunction

  // Drive one cycle of inputs, expect the given registered outputs after the edge.
  task automatic step(input logic r, input logic e, input logic s, input state_t st, input int c,
                      input logic eof, input logic done, input logic care, input string name);
    logic [W-1:0]  exp_v, act_v, mask;
    logic [RW-1:0] c_v;
    logic          care_v;
    c_v    = c;
    rst    = r;
    enable = e;
    sync   = s;
    exp_q.push_back({st, c_v, (st != IDLE), eof, done});
    care_q.push_back(care);
    @(posedge clk);
    #1;
    exp_v  = exp_q.pop_front();
    care_v = care_q.pop_front();
    act_v  = {tdd_cstate, tdd_counter, tdd_enable, tdd_endof_frame, burst_done};
    mask   = '1;
    if (!care_v) mask[RW+2:3] = '0;
    n_vec++;
    if ((act_v & mask) !== (exp_v & mask)) begin
      n_fail++;
      $display("FAIL %s @%0t: got state=%0d cnt=%0d en=%0b eof=%0b done=%0b, want state=%0d cnt=%0d en=%0b eof=%0b done=%0b",
               name, $time, act_v[W-1 -: 2], act_v[RW+2:3], act_v[2], act_v[1], act_v[0],
               exp_v[W-1 -: 2], exp_v[RW+2:3], exp_v[2], exp_v[1], exp_v[0]);
    end
  endtask

  task automatic run(input int from, input int to, input int flen, input string name);
    for (int c = from; c <= to; c++) step(1'b0, 1'b1, 1'b0, RUNNING, c, (c == flen), 1'b0, 1'b1, name);
  endtask

  task automatic config_arm(input int d, input int fl, input int b);
    step(1'b0, 1'b0, 1'b0, IDLE, 0, 1'b0, 1'b0, 1'b1, "to_idle");
    startup_delay = d;
    frame_length  = fl;
    burst_count   = b;
    step(1'b0, 1'b1, 1'b0, ARMED, 0, 1'b0, 1'b0, 1'b1, "arm");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic sync_pulse;
`ifdef AXI_TDD_NG_SYNC_RESTART_EN
    sync_pulse = 1'b0;
`else
    sync_pulse = 1'b1;
`endif
    rst = 1'b1; enable = 1'b0; sync = 1'b0;
    startup_delay = 3; frame_length = 9; burst_count = 2;

    // Reference burst: delay 3, frame_length 9, two frames.
    add(1, 0, 0, IDLE, 0, 0, 0);
    add(1, 0, 0, IDLE, 0, 0, 0);
    add(1, 1, 0, IDLE, 0, 0, 0);
    add(0, 1, 0, ARMED, 0, 0, 0);
    add(0, 1, 0, ARMED, 0, 0, 0);
    add(0, 1, 1, WAITING, 0, 0, 0);
    add(0, 1, 0, WAITING, 1, 0, 0);
    add(0, 1, 0, WAITING, 2, 0, 0);
    for (int f = 0; f < 2; f++)
      for (int c = 0; c <= 9; c++) add(0, 1, 0, RUNNING, c, (c == 9), 0);
    add(0, 1, 0, ARMED, 0, 0, 1);
    add(0, 1, 0, ARMED, 0, 0, 0);
    foreach (tbl[i])
      step(tbl[i].rst, tbl[i].en, tbl[i].sy, tbl[i].st, tbl[i].cnt, tbl[i].eof, tbl[i].done, 1'b1, "burst_tbl");

    // Infinite burst, frame_length 4, 100 frames, then disable at counter 2.
    config_arm(0, 4, 0);
    step(1'b0, 1'b1, 1'b1, RUNNING, 0, 1'b0, 1'b0, 1'b1, "inf_sync");
    for (int k = 1; k < 500; k++) step(1'b0, 1'b1, 1'b0, RUNNING, k % 5, (k % 5) == 4, 1'b0, 1'b1, "inf_run");
    run(0, 2, 4, "pre_dis");
    step(1'b0, 1'b0, 1'b0, RUNNING, 2, 1'b1, 1'b0, 1'b0, "dis_strobe");
    step(1'b0, 1'b0, 1'b0, IDLE, 0, 1'b0, 1'b0, 1'b1, "dis_idle");

    // Shadowed frame_length and ignored sync while running, then disable on the end-of-frame cycle.
    config_arm(0, 9, 0);
    step(1'b0, 1'b1, 1'b1, RUNNING, 0, 1'b0, 1'b0, 1'b1, "shd_sync");
    run(1, 4, 9, "shd_run");
    frame_length = 5;
    step(1'b0, 1'b1, sync_pulse, RUNNING, 5, 1'b0, 1'b0, 1'b1, "shd_ignsync");
    run(6, 9, 9, "shd_run");
    run(0, 9, 9, "shd_run2");
    step(1'b0, 1'b0, 1'b0, IDLE, 0, 1'b0, 1'b0, 1'b1, "eof_dis");
    step(1'b0, 1'b0, 1'b0, IDLE, 0, 1'b0, 1'b0, 1'b1, "eof_dis_once");

    // Last frame coinciding with sync: sync dropped.
    config_arm(0, 2, 1);
    step(1'b0, 1'b1, 1'b1, RUNNING, 0, 1'b0, 1'b0, 1'b1, "last_go");
    run(1, 2, 2, "last_run");
    step(1'b0, 1'b1, 1'b1, ARMED, 0, 1'b0, 1'b1, 1'b1, "last_sync");
    step(1'b0, 1'b1, 1'b0, ARMED, 0, 1'b0, 1'b0, 1'b1, "sync_drop");

    // One-cycle frames, three per burst.
    config_arm(0, 0, 3);
    step(1'b0, 1'b1, 1'b1, RUNNING, 0, 1'b1, 1'b0, 1'b1, "fl0_f1");
    step(1'b0, 1'b1, 1'b0, RUNNING, 0, 1'b1, 1'b0, 1'b1, "fl0_f2");
    step(1'b0, 1'b1, 1'b0, RUNNING, 0, 1'b1, 1'b0, 1'b1, "fl0_f3");
    step(1'b0, 1'b1, 1'b0, ARMED, 0, 1'b0, 1'b1, 1'b1, "fl0_done");

    // Disable in WAITING, and sync in IDLE ignored.
    config_arm(2, 5, 1);
    step(1'b0, 1'b1, 1'b1, WAITING, 0, 1'b0, 1'b0, 1'b1, "wait0");
    step(1'b0, 1'b1, 1'b0, WAITING, 1, 1'b0, 1'b0, 1'b1, "wait1");
    step(1'b0, 1'b0, 1'b0, IDLE, 0, 1'b0, 1'b0, 1'b1, "wait_dis");
    step(1'b0, 1'b0, 1'b1, IDLE, 0, 1'b0, 1'b0, 1'b1, "idle_sync");

`ifdef AXI_TDD_NG_SYNC_RESTART_EN
    // Restart in the second frame: strobe, then a fresh two-frame burst.
    config_arm(0, 9, 2);
    step(1'b0, 1'b1, 1'b1, RUNNING, 0, 1'b0, 1'b0, 1'b1, "rs_go");
    run(1, 9, 9, "rs_f1");
    run(0, 6, 9, "rs_f2");
    step(1'b0, 1'b1, 1'b1, RUNNING, 6, 1'b1, 1'b0, 1'b0, "rs_strobe");
    run(0, 9, 9, "rs_n1");
    run(0, 9, 9, "rs_n2");
    step(1'b0, 1'b1, 1'b0, ARMED, 0, 1'b0, 1'b1, 1'b1, "rs_done");
`endif

    // Reset mid-frame wins over enable.
    config_arm(0, 9, 0);
    step(1'b0, 1'b1, 1'b1, RUNNING, 0, 1'b0, 1'b0, 1'b1, "rm_go");
    run(1, 3, 9, "rm_run");
    step(1'b1, 1'b1, 1'b0, IDLE, 0, 1'b0, 1'b0, 1'b1, "rst_mid");
    step(1'b0, 1'b0, 1'b0, IDLE, 0, 1'b0, 1'b0, 1'b1, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_tdd_ng_counter.md
# axi_tdd_ng_counter

- Timing master for the TDD engine: arms on software enable, waits for a sync pulse, runs an optional startup delay, then runs a frame counter for a configured number of frames.
- Drives the shared `tdd_counter`, `tdd_cstate`, `tdd_enable` and `tdd_endof_frame` bus that every `axi_tdd_ng_channel` instance consumes.
- Sits between the register map and the channel array.

## Interface

- `REGISTER_WIDTH`, 32: width of the counter and of all timing values.
- `BURST_WIDTH`, 32: width of `burst_count` and of the internal frame counter.
- `clk`  in  1  core clock.
- `rst`  in  1  reset; synchronous, active-high.
- `enable`  in  1  software enable, level.
- `sync`  in  1  start pulse, single-cycle, already synchronised to `clk`.
- `startup_delay`  in  REGISTER_WIDTH  cycles spent in WAITING before the first frame.
- `frame_length`  in  REGISTER_WIDTH  last counter value of a frame.
- `burst_count`  in  BURST_WIDTH  number of frames per sync; 0 means infinite.
- `tdd_counter`  out  REGISTER_WIDTH  frame or delay counter.
- `tdd_cstate`  out  `axi_tdd_ng_pkg::state_t`  current state.
- `tdd_enable`  out  1  clock enable for channels.
- `tdd_endof_frame`  out  1  end-of-frame strobe.
- `burst_done`  out  1  one-cycle strobe after the last frame of a burst.

## Operation

- States: IDLE, ARMED, WAITING, RUNNING (`axi_tdd_ng_pkg` encoding). All outputs are registered.
- Reset values: state IDLE, `tdd_counter`=0, `tdd_enable`=0, `tdd_endof_frame`=0, `burst_done`=0.
- **IDLE**
  - Goes to ARMED when `enable`=1.
  - On that transition, `startup_delay`, `frame_length` and `burst_count` are latched into shadow registers; the live inputs are ignored until the next IDLE→ARMED transition.
- **ARMED**
  - `tdd_counter`=0.
  - On `sync`=1: go to WAITING if the shadow delay ≠ 0, else go to RUNNING.
  - The frame counter is cleared.
- **WAITING**
  - `tdd_counter` increments from 0.
  - When it equals delay−1, the next state is RUNNING with counter 0.
- **RUNNING**
  - `tdd_counter` increments 0..`frame_length`.
  - `tdd_endof_frame`=1 in exactly the cycle where `tdd_counter`==`frame_length`.
  - Next cycle, if frames remain: counter 0, still RUNNING.
  - Otherwise: state ARMED, counter 0, `burst_done`=1 for one cycle.
  - Frames remain when `burst_count`=0, or the completed-frame count+1 < `burst_count`.
- `frame_length`=0 gives one-cycle frames, with `tdd_endof_frame` held high every RUNNING cycle.
- `tdd_enable`=1 in every state except IDLE.
- **Disable while RUNNING:**
  - Next cycle: `tdd_endof_frame`=1 with state RUNNING and `tdd_enable`=1, so channels return to idle polarity.
  - Cycle after: IDLE, `tdd_enable`=0, counter 0.
- **Disable in ARMED or WAITING:** IDLE next cycle.
- `sync` in IDLE or WAITING is ignored. `sync` in RUNNING is ignored unless the macro below is defined.
- Counters wrap modulo 2^width; the comparisons above prevent wrap in legal use.
- `rst` has priority over all other inputs, mid-frame included.

## Timing

- `sync` sampled at edge N in ARMED:
  - With delay D ≠ 0: `tdd_cstate`=WAITING and `tdd_counter`=0 after N+1; RUNNING with counter 0 after edge N+1+D.
  - With D=0: RUNNING with counter 0 after N+1.
- A frame lasts `frame_length`+1 cycles.
- `enable` rising at edge N: `tdd_cstate`=ARMED and `tdd_enable`=1 after N+1.
- Simultaneous end of frame and disable: the end-of-frame strobe is issued once, then IDLE. No second strobe.
- Simultaneous last frame and `sync`: go to ARMED; that `sync` is dropped.

## Configuration

- Macro: `AXI_TDD_NG_SYNC_RESTART_EN`.
- **Defined:** `sync`=1 while RUNNING forces `tdd_endof_frame`=1 next cycle.
  - Then counter 0, frame count cleared, WAITING or RUNNING per the delay, as from ARMED.
- **Undefined:** `sync` outside ARMED has no effect, and the restart logic is absent.

## Test plan

- **Reset/arm:** reset asserted, then `enable`=1 → all outputs 0 during reset; ARMED and `tdd_enable`=1 one cycle after `enable`.
- **Single burst:** delay=3, frame_length=9, burst=2, one `sync`.
  - Required: 3 WAITING cycles (counter 0,1,2), then two frames of counter 0..9 with `tdd_endof_frame` at each 9.
  - Then ARMED with `burst_done` pulsed once.
- **Infinite burst:** burst=0, delay=0, frame_length=4 → `tdd_endof_frame` every 5 cycles for 100 frames; never returns to ARMED.
- **Mid-frame disable:** `enable`→0 at counter 2 → one `tdd_endof_frame` cycle in RUNNING, then IDLE, `tdd_enable`=0, counter 0.
- **Shadowing and ignored sync:** change `frame_length` 9→5 while RUNNING and pulse `sync` (macro off) → frames stay 10 cycles; `sync` has no effect.
- **Restart (macro on):** `sync` at counter 6, frame_length=9, delay=0 → `tdd_endof_frame` next cycle, then counter restarts at 0; burst count restarts.
